// File: rtl/branch_predict_cmp.sv
// Decode-stage branch comparator with a 2-bit bimodal BHT
// and saturating branch/mispredict statistic counters.
module branch_predict_cmp #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] F_pc,
  output logic             F_predTaken,
  input  logic             D_valid,
  input  logic [WIDTH-1:0] D_pc,
  input  logic [2:0]       D_op,
  input  logic [WIDTH-1:0] D_RD1,
  input  logic [WIDTH-1:0] D_RD2,
  input  logic             D_predTaken,
  input  logic             D_stall,
  output logic             D_isBranch,
  output logic             D_mispredict,
  output logic [CNT_W-1:0] branchCnt,
  output logic [CNT_W-1:0] missCnt
);

  localparam int DEPTH = 2 ** IDX_BITS;

  logic [1:0]          bht [DEPTH];
  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] d_idx;
  logic [1:0]          cur_ctr;
  logic [1:0]          nxt_ctr;
  logic                op_beq;
  logic                op_bne;
  logic                op_blez;
  logic                op_bgtz;
  logic                op_bltz;
  logic                op_bgez;
  logic                rd1_neg;
  logic                rd1_zero;
  logic                br_evt;
  logic                upd;
  logic                unused_pc_bits;

  assign f_idx = F_pc[IDX_BITS+1:2];
  assign d_idx = D_pc[IDX_BITS+1:2];

  assign unused_pc_bits = ^{F_pc[WIDTH-1:IDX_BITS+2], F_pc[1:0],
                            D_pc[WIDTH-1:IDX_BITS+2], D_pc[1:0]};

  assign op_beq  = (D_op == 3'd1);
  assign op_bne  = (D_op == 3'd2);
  assign op_blez = (D_op == 3'd3);
  assign op_bgtz = (D_op == 3'd4);
  assign op_bltz = (D_op == 3'd5);
  assign op_bgez = (D_op == 3'd6);

  assign rd1_neg  = D_RD1[WIDTH-1];
  assign rd1_zero = (D_RD1 == '0);

  // Resolve the branch condition for the decoded compare mode.
  always_comb begin
    D_isBranch = 1'b0;
    unique case (1'b1)
      op_beq:  D_isBranch = (D_RD1 == D_RD2);
      op_bne:  D_isBranch = (D_RD1 != D_RD2);
      op_blez: D_isBranch = rd1_neg | rd1_zero;
      op_bgtz: D_isBranch = ~rd1_neg & ~rd1_zero;
      op_bltz: D_isBranch = rd1_neg;
      op_bgez: D_isBranch = ~rd1_neg;
      default: D_isBranch = 1'b0;
    endcase
  end

  assign br_evt = D_valid & (op_beq | op_bne | op_blez |
                             op_bgtz | op_bltz | op_bgez);
  assign upd    = br_evt & ~D_stall;

  assign D_mispredict = br_evt & (D_isBranch != D_predTaken);

  assign F_predTaken = bht[f_idx][1];

  assign cur_ctr = bht[d_idx];

  // Saturating step of the counter being trained.
  always_comb begin
    nxt_ctr = cur_ctr;
    if (D_isBranch) begin
      if (cur_ctr != 2'd3) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'd0) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  // BHT write; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'd1;
    end else if (upd) begin
      bht[d_idx] <= nxt_ctr;
    end
  end

  // Statistic counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branchCnt <= '0;
      missCnt   <= '0;
    end else if (upd) begin
      if (branchCnt != '1) branchCnt <= branchCnt + CNT_W'(1);
      if (D_mispredict && (missCnt != '1)) missCnt <= missCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_cmp.sv
// Directed bench for branch_predict_cmp: compare modes,
// BHT training, bypass timing, stall, saturation, async reset.
module tb_branch_predict_cmp;

  localparam int WIDTH = 32;
  localparam int IDXB  = 4;
  localparam int CW    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] F_pc;
  logic             F_predTaken;
  logic             D_valid;
  logic [WIDTH-1:0] D_pc;
  logic [2:0]       D_op;
  logic [WIDTH-1:0] D_RD1;
  logic [WIDTH-1:0] D_RD2;
  logic             D_predTaken;
  logic             D_stall;
  logic             D_isBranch;
  logic             D_mispredict;
  logic [CW-1:0]    branchCnt;
  logic [CW-1:0]    missCnt;

  int checks = 0;
  int errors = 0;

  branch_predict_cmp #(
    .WIDTH(WIDTH),
    .IDX_BITS(IDXB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .F_pc(F_pc),
    .F_predTaken(F_predTaken),
    .D_valid(D_valid),
    .D_pc(D_pc),
    .D_op(D_op),
    .D_RD1(D_RD1),
    .D_RD2(D_RD2),
    .D_predTaken(D_predTaken),
    .D_stall(D_stall),
    .D_isBranch(D_isBranch),
    .D_mispredict(D_mispredict),
    .branchCnt(branchCnt),
    .missCnt(missCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pred_chk(input string tag,
                          input logic [31:0] pc,
                          input logic exp);
    F_pc = pc;
    #1;
    check(tag, 32'(F_predTaken), 32'(exp));
  endtask

  task automatic cnt_chk(input string tag,
                         input int b,
                         input int m);
    check({tag, "_bcnt"}, 32'(branchCnt), 32'(b));
    check({tag, "_mcnt"}, 32'(missCnt), 32'(m));
  endtask

  task automatic set_br(input logic [31:0] pc,
                        input logic taken,
                        input logic pred);
    D_valid     = 1'b1;
    D_op        = 3'd1;
    D_pc        = pc;
    D_RD1       = 32'd5;
    D_RD2       = taken ? 32'd5 : 32'd6;
    D_predTaken = pred;
  endtask

  // Compare-mode vectors: {op, rd1, expected outcome}, rd2 = 0
  logic [2:0]  v_op  [11];
  logic [31:0] v_rd1 [11];
  logic        v_exp [11];

  initial begin
    v_op[0] = 3'd1; v_rd1[0] = 32'hFFFF_FFFF; v_exp[0] = 1'b0;
    v_op[1] = 3'd2; v_rd1[1] = 32'hFFFF_FFFF; v_exp[1] = 1'b1;
    v_op[2] = 3'd3; v_rd1[2] = 32'hFFFF_FFFF; v_exp[2] = 1'b1;
    v_op[3] = 3'd4; v_rd1[3] = 32'hFFFF_FFFF; v_exp[3] = 1'b0;
    v_op[4] = 3'd5; v_rd1[4] = 32'hFFFF_FFFF; v_exp[4] = 1'b1;
    v_op[5] = 3'd6; v_rd1[5] = 32'hFFFF_FFFF; v_exp[5] = 1'b0;
    v_op[6] = 3'd3; v_rd1[6] = 32'h0;         v_exp[6] = 1'b1;
    v_op[7] = 3'd6; v_rd1[7] = 32'h0;         v_exp[7] = 1'b1;
    v_op[8] = 3'd5; v_rd1[8] = 32'h0;         v_exp[8] = 1'b0;
    v_op[9] = 3'd0; v_rd1[9] = 32'h0;         v_exp[9] = 1'b0;
    v_op[10] = 3'd7; v_rd1[10] = 32'h0;       v_exp[10] = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    F_pc        = 32'h3010;
    D_valid     = 1'b0;
    D_pc        = '0;
    D_op        = 3'd0;
    D_RD1       = '0;
    D_RD2       = '0;
    D_predTaken = 1'b0;
    D_stall     = 1'b0;
    #3;
    check("rst_pred", 32'(F_predTaken), 32'd0);
    cnt_chk("rst", 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // compare modes, no valid so nothing trains
    D_RD2 = 32'h0;
    for (int i = 0; i < 11; i++) begin
      D_op  = v_op[i];
      D_RD1 = v_rd1[i];
      #1;
      check($sformatf("cmp%0d_op%0d", i, v_op[i]),
            32'(D_isBranch), 32'(v_exp[i]));
      check($sformatf("cmp%0d_nomis", i), 32'(D_mispredict), 32'd0);
    end
    @(negedge clk);

    // train 0x3010 taken twice
    F_pc = 32'h3010;
    set_br(32'h3010, 1'b1, 1'b0);
    #1;
    check("tr_isbr", 32'(D_isBranch), 32'd1);
    check("tr_mis", 32'(D_mispredict), 32'd1);
    check("tr_pre", 32'(F_predTaken), 32'd0);
    @(negedge clk);
    D_valid = 1'b0;
    pred_chk("tr_c2", 32'h3010, 1'b1);
    pred_chk("tr_nb1", 32'h3014, 1'b0);
    set_br(32'h3010, 1'b1, 1'b0);
    @(negedge clk);
    D_valid = 1'b0;
    pred_chk("tr_c3", 32'h3010, 1'b1);

    // untrain twice
    set_br(32'h3010, 1'b0, 1'b1);
    #1;
    check("nt_isbr", 32'(D_isBranch), 32'd0);
    check("nt_mis", 32'(D_mispredict), 32'd1);
    @(negedge clk);
    D_valid = 1'b0;
    pred_chk("nt_c2", 32'h3010, 1'b1);
    set_br(32'h3010, 1'b0, 1'b1);
    @(negedge clk);
    D_valid = 1'b0;
    pred_chk("nt_c1", 32'h3010, 1'b0);
    pred_chk("nt_nb", 32'h3014, 1'b0);
    cnt_chk("tr", 4, 4);

    // alias index 0: pre-update read in same cycle
    set_br(32'h3000, 1'b1, 1'b1);
    F_pc = 32'h3040;
    #1;
    check("al_same", 32'(F_predTaken), 32'd0);
    check("al_nomis", 32'(D_mispredict), 32'd0);
    @(negedge clk);
    D_valid = 1'b0;
    #1;
    check("al_next", 32'(F_predTaken), 32'd1);
    cnt_chk("al", 5, 4);

    // stall holds all state
    set_br(32'h3020, 1'b1, 1'b0);
    F_pc    = 32'h3020;
    D_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("st_mis%0d", i), 32'(D_mispredict), 32'd1);
      @(negedge clk);
    end
    D_stall = 1'b0;
    D_valid = 1'b0;
    pred_chk("st_pred", 32'h3020, 1'b0);
    cnt_chk("st", 5, 4);

    // reserved op with valid: no effect
    D_valid = 1'b1;
    D_op    = 3'd7;
    #1;
    check("r7_mis", 32'(D_mispredict), 32'd0);
    @(negedge clk);
    D_valid = 1'b0;
    cnt_chk("r7", 5, 4);

    // saturation of statistic counters
    set_br(32'h3024, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    cnt_chk("sat10", 15, 14);
    repeat (10) @(negedge clk);
    D_valid = 1'b0;
    cnt_chk("sat20", 15, 15);
    D_valid = 1'b1;
    D_op    = 3'd7;
    @(negedge clk);
    D_valid = 1'b0;
    D_op    = 3'd1;
    cnt_chk("sat_r7", 15, 15);
    pred_chk("sat_pred", 32'h3024, 1'b1);

    // async reset between edges with a pending update
    set_br(32'h3010, 1'b1, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check("ar_pred", 32'(F_predTaken), 32'd0);
    cnt_chk("ar", 0, 0);
    pred_chk("ar_p10", 32'h3000, 1'b0);
    @(negedge clk);
    D_valid = 1'b0;
    reset   = 1'b1;
    pred_chk("ar_disc", 32'h3010, 1'b0);
    set_br(32'h3010, 1'b1, 1'b1);
    @(negedge clk);
    D_valid = 1'b0;
    pred_chk("ar_run", 32'h3010, 1'b1);
    cnt_chk("ar_run", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
